// File: rtl/instr_sequencer_if.sv
// Bundle between the instruction sequencer and its environment: instruction
// handshake, memory and ALU control, and architectural state.
interface instr_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       mem_enable;
  logic       read_write;
  logic [3:0] address_bus;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;
  logic       alu_enable;
  logic [2:0] mode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] sum;
  logic       zero_flag;
  logic       carry_flag;
  logic [7:0] acc;
  logic       z;
  logic       c;
  logic       done;

  modport master (
    input  instr_valid, instr, imm, data_bus_out, sum, zero_flag, carry_flag,
    output instr_ready, mem_enable, read_write, address_bus, data_bus_in,
           alu_enable, mode, alu_a, alu_b, acc, z, c, done
  );

  modport slave (
    output instr_valid, instr, imm, data_bus_out, sum, zero_flag, carry_flag,
    input  instr_ready, mem_enable, read_write, address_bus, data_bus_in,
           alu_enable, mode, alu_a, alu_b, acc, z, c, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: steps one instruction through memory read, ALU execute
// and memory write-back phases, holding the accumulator and zero/carry flags.
module instr_sequencer (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, RDW, EX, EXW, WR} state_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_MI  = 4'h2;
  localparam logic [3:0] OP_MR  = 4'h3;
  localparam logic [3:0] OP_CM  = 4'h7;
  localparam logic [3:0] OP_CMI = 4'hF;

  function automatic logic is_imm_alu(input logic [3:0] op);
    return op inside {4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  endfunction

  function automatic logic [2:0] alu_mode(input logic [3:0] op);
    logic [2:0] m;
    unique case (op)
      4'h4, 4'hC: m = 3'b000;
      4'h5, 4'hD: m = 3'b001;
      4'h6, 4'hE: m = 3'b010;
      4'h8, 4'h9: m = 3'b011;
      4'hA, 4'hB: m = 3'b100;
      4'h7, 4'hF: m = 3'b101;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

  state_t     state, state_nx;
  logic [7:0] ir, imr, opb, acc_q;
  logic       z_q, c_q, done_q, last_step;
  logic [3:0] op, new_op;

  assign op     = ir[7:4];
  assign new_op = bus.instr[7:4];

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    last_step = 1'b0;
    unique case (state)
      IDLE: if (bus.instr_valid) begin
        if (new_op == OP_ST || new_op == OP_MI) state_nx = WR;
        else if (is_imm_alu(new_op))            state_nx = EX;
        else                                    state_nx = RD;
      end
      RD:  state_nx = RDW;
      RDW: begin
        if (op == OP_LD) begin
          state_nx  = IDLE;
          last_step = 1'b1;
        end else if (op == OP_MR) state_nx = WR;
        else                      state_nx = EX;
      end
      EX:  state_nx = EXW;
      EXW: begin
        state_nx  = IDLE;
        last_step = 1'b1;
      end
      WR: begin
        state_nx  = IDLE;
        last_step = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory/ALU controls depend only on state and latched registers.
  always_comb begin
    bus.mem_enable  = 1'b0;
    bus.read_write  = 1'b1;
    bus.address_bus = 4'h0;
    bus.data_bus_in = 8'h00;
    bus.alu_enable  = 1'b0;
    bus.mode        = 3'b000;
    unique case (state)
      RD: begin
        bus.mem_enable  = 1'b1;
        bus.address_bus = ir[3:0];
      end
      EX: begin
        bus.alu_enable = 1'b1;
        bus.mode       = alu_mode(op);
      end
      WR: begin
        bus.mem_enable = 1'b1;
        bus.read_write = 1'b0;
        if (op == OP_MR) begin
          bus.address_bus = acc_q[3:0];
          bus.data_bus_in = opb;
        end else begin
          bus.address_bus = ir[3:0];
          bus.data_bus_in = (op == OP_MI) ? imr : acc_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc_q  <= 8'h00;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_step;
      if (state == RDW && op == OP_LD) acc_q <= bus.data_bus_out;
      if (state == EXW) begin
        if (op != OP_CM && op != OP_CMI) acc_q <= bus.sum;
        z_q <= bus.zero_flag;
        c_q <= bus.carry_flag;
      end
    end
  end

  // NOTE: operand registers are not reset; they are always loaded before any state reads them.
  always_ff @(posedge clk) begin
    if (bus.instr_valid && state == IDLE) begin
      ir  <= bus.instr;
      imr <= bus.imm;
    end
    if (state == RDW) opb <= bus.data_bus_out;
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.alu_a       = acc_q;
  assign bus.alu_b       = is_imm_alu(op) ? imr : opb;
  assign bus.acc         = acc_q;
  assign bus.z           = z_q;
  assign bus.c           = c_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with behavioural memory/ALU models
// and an instruction-level reference model of accumulator, flags and memory.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();
  instr_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic [7:0] ref_acc = 8'h00;
  logic       ref_z = 1'b0;
  logic       ref_c = 1'b0;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int         wr_count;

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clk)
    if (bus.mem_enable) begin
      if (bus.read_write) bus.data_bus_out <= mem[bus.address_bus];
      else                mem[bus.address_bus] <= bus.data_bus_in;
    end

  function automatic logic [8:0] alu_fn(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      3'd0:       return {1'b0, a} + {1'b0, b};
      3'd1, 3'd5: return {1'b0, a} - {1'b0, b};
      3'd2:       return {1'b0, a & b};
      3'd3:       return {1'b0, a | b};
      3'd4:       return {1'b0, a ^ b};
      default:    return 9'h000;
    endcase
  endfunction

  always @(posedge clk)
    if (bus.alu_enable) begin
      {bus.carry_flag, bus.sum} <= alu_fn(bus.mode, bus.alu_a, bus.alu_b);
      bus.zero_flag <= (alu_fn(bus.mode, bus.alu_a, bus.alu_b) & 9'h0FF) == 9'h000;
    end

  // Architectural effect of one instruction, plus its accept-to-done latency.
  task automatic ref_exec(input logic [3:0] op, input logic [3:0] a, input logic [7:0] imm, output int lat);
    logic [7:0] b, res;
    logic [8:0] w;
    logic       cy, reg_form;
    case (op)
      4'h0: begin ref_acc = ref_mem[a]; lat = 3; end
      4'h1: begin ref_mem[a] = ref_acc; lat = 2; end
      4'h2: begin ref_mem[a] = imm; lat = 2; end
      4'h3: begin ref_mem[ref_acc[3:0]] = ref_mem[a]; lat = 4; end
      default: begin
        reg_form = op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
        b   = reg_form ? ref_mem[a] : imm;
        lat = reg_form ? 5 : 3;
        res = 8'h00;
        cy  = 1'b0;
        case (op)
          4'h4, 4'hC: begin w = {1'b0, ref_acc} + {1'b0, b}; res = w[7:0]; cy = w[8]; end
          4'h5, 4'hD: begin res = ref_acc - b; cy = ref_acc < b; end
          4'h6, 4'hE: res = ref_acc & b;
          4'h8, 4'h9: res = ref_acc | b;
          4'hA, 4'hB: res = ref_acc ^ b;
          default: ;
        endcase
        if (op == 4'h7 || op == 4'hF) begin
          ref_z = (ref_acc == b);
          ref_c = (ref_acc < b);
        end else begin
          ref_z   = (res == 8'h00);
          ref_c   = cy;
          ref_acc = res;
        end
      end
    endcase
  endtask

  // Offer one instruction at a negedge with the sequencer idle; run it to its done cycle.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [7:0] imm, input bit hold);
    int lat, n;
    bit seen_ready;
    total++;
    if (bus.instr_ready !== 1'b1) begin
      $display("FAIL ready_at_offer op=%h: got %b want 1", op, bus.instr_ready); bad++;
    end
    bus.instr = {op, a};
    bus.imm = imm;
    bus.instr_valid = 1'b1;
    ref_exec(op, a, imm, lat);
    n = 0;
    seen_ready = 0;
    wr_count = 0;
    while (!seen_ready && n < 20) begin
      @(negedge clk);
      n++;
      if (!hold) bus.instr_valid = 1'b0;
      if (bus.mem_enable === 1'b1 && bus.read_write === 1'b0) begin
        wr_addr = bus.address_bus;
        wr_data = bus.data_bus_in;
        wr_count++;
      end
      if (bus.instr_ready === 1'b1) seen_ready = 1;
      else begin
        total++;
        if (bus.done !== 1'b0) begin
          $display("FAIL busy_done op=%h cycle %0d: got %b want 0", op, n, bus.done); bad++;
        end
      end
    end
    total++;
    if (!seen_ready) begin $display("FAIL timeout op=%h: no return to idle in 20 cycles", op); bad++; end
    total++;
    if (n != lat) begin $display("FAIL latency op=%h: got %0d want %0d", op, n, lat); bad++; end
    total++;
    if (bus.done !== 1'b1) begin $display("FAIL done_pulse op=%h: got %b want 1", op, bus.done); bad++; end
    total++;
    if (bus.acc !== ref_acc) begin $display("FAIL acc op=%h: got %h want %h", op, bus.acc, ref_acc); bad++; end
    total++;
    if (bus.z !== ref_z || bus.c !== ref_c) begin
      $display("FAIL flags op=%h: got z=%b c=%b want z=%b c=%b", op, bus.z, bus.c, ref_z, ref_c); bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    bus.imm = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
      $display("FAIL reset_handshake: got ready=%b done=%b want 1 0", bus.instr_ready, bus.done); bad++;
    end
    total++;
    if (bus.acc !== 8'h00 || bus.z !== 1'b0 || bus.c !== 1'b0) begin
      $display("FAIL reset_state: got acc=%h z=%b c=%b want 00 0 0", bus.acc, bus.z, bus.c); bad++;
    end
    total++;
    if (bus.mem_enable !== 1'b0 || bus.alu_enable !== 1'b0 || bus.read_write !== 1'b1 ||
        bus.address_bus !== 4'h0 || bus.data_bus_in !== 8'h00 || bus.mode !== 3'b000) begin
      $display("FAIL reset_idle_outputs: got me=%b ae=%b rw=%b addr=%h wd=%h mode=%b want 0 0 1 0 00 000",
               bus.mem_enable, bus.alu_enable, bus.read_write, bus.address_bus, bus.data_bus_in, bus.mode);
      bad++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mem_ops;
    issue(4'h2, 4'h5, 8'h09, 0);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin $display("FAIL done_single_cycle: got %b want 0", bus.done); bad++; end
    issue(4'h0, 4'h5, 8'h00, 0);
    total++;
    if (bus.acc !== 8'h09 || bus.z !== 1'b0 || bus.c !== 1'b0) begin
      $display("FAIL ld_after_mi: got acc=%h z=%b c=%b want 09 0 0", bus.acc, bus.z, bus.c); bad++;
    end
  endtask

  task automatic test_imm_alu;
    issue(4'hC, 4'h0, 8'h05, 0);
    total++;
    if (bus.acc !== 8'd14) begin $display("FAIL smi_result: got %h want 0e", bus.acc); bad++; end
    issue(4'h1, 4'h1, 8'h00, 0);
    issue(4'h0, 4'h1, 8'h00, 0);
    total++;
    if (bus.acc !== 8'd14) begin $display("FAIL st_ld_roundtrip: got %h want 0e", bus.acc); bad++; end
  endtask

  task automatic test_reg_alu;
    issue(4'h2, 4'h3, 8'hF0, 0);
    issue(4'h0, 4'h3, 8'h00, 0);
    issue(4'h2, 4'h2, 8'h20, 0);
    issue(4'h4, 4'h2, 8'h00, 0);
    total++;
    if (bus.acc !== 8'h10 || bus.c !== 1'b1) begin
      $display("FAIL sum_wrap: got acc=%h c=%b want 10 1", bus.acc, bus.c); bad++;
    end
    issue(4'hF, 4'h0, 8'h10, 0);
    total++;
    if (bus.acc !== 8'h10 || bus.z !== 1'b1) begin
      $display("FAIL cmi_equal: got acc=%h z=%b want 10 1", bus.acc, bus.z); bad++;
    end
  endtask

  task automatic test_mr;
    issue(4'h2, 4'h4, 8'h03, 0);
    issue(4'h0, 4'h4, 8'h00, 0);
    issue(4'h2, 4'h7, 8'hAA, 0);
    issue(4'h3, 4'h7, 8'h00, 0);
    total++;
    if (wr_count != 1 || wr_addr !== 4'h3 || wr_data !== 8'hAA) begin
      $display("FAIL mr_write_cycle: got n=%0d addr=%h data=%h want 1 3 aa", wr_count, wr_addr, wr_data); bad++;
    end
    total++;
    if (mem[3] !== 8'hAA) begin $display("FAIL mr_mem: got %h want aa", mem[3]); bad++; end
    issue(4'h3, 4'h3, 8'h00, 0);
    total++;
    if (wr_count != 1 || wr_addr !== 4'h3 || wr_data !== 8'hAA) begin
      $display("FAIL mr_self_copy: got n=%0d addr=%h data=%h want 1 3 aa", wr_count, wr_addr, wr_data); bad++;
    end
  endtask

  task automatic test_back_to_back;
    issue(4'h2, 4'h6, 8'h11, 1);
    issue(4'h0, 4'h6, 8'h00, 1);
    issue(4'hD, 4'h0, 8'h01, 1);
    issue(4'h4, 4'h6, 8'h00, 1);
    bus.instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom), bit'($urandom_range(0, 1)));
    bus.instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bus.instr = 8'h42;
    bus.imm = 8'h00;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.alu_enable !== 1'b1) begin $display("FAIL mid_in_ex: got alu_enable=%b want 1", bus.alu_enable); bad++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_acc = 8'h00;
    ref_z = 1'b0;
    ref_c = 1'b0;
    total++;
    if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.alu_enable !== 1'b0 || bus.mem_enable !== 1'b0) begin
      $display("FAIL mid_reset_idle: got ready=%b done=%b ae=%b me=%b want 1 0 0 0",
               bus.instr_ready, bus.done, bus.alu_enable, bus.mem_enable); bad++;
    end
    total++;
    if (bus.acc !== 8'h00 || bus.z !== 1'b0 || bus.c !== 1'b0) begin
      $display("FAIL mid_reset_state: got acc=%h z=%b c=%b want 00 0 0", bus.acc, bus.z, bus.c); bad++;
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.acc !== 8'h00) begin
      $display("FAIL mid_reset_no_done: got done=%b acc=%h want 0 00", bus.done, bus.acc); bad++;
    end
  endtask

  task automatic test_memory_image;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (mem[i] !== ref_mem[i]) begin
        $display("FAIL mem_image[%0d]: got %h want %h", i, mem[i], ref_mem[i]); bad++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_mem_ops;
    test_imm_alu;
    test_reg_alu;
    test_mr;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_memory_image;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the 8-bit datapath: accepts one decoded instruction at a time, drives the synchronous `memory` and registered `alu` blocks through read, execute and write-back phases, and holds the architectural accumulator and flags. It sits directly upstream of `memory` and `alu`, replacing the hand-timed enable/address/mode stimulus currently applied to them.

## Interface
- Parameters: none (8-bit data, 4-bit address and 3-bit ALU mode are fixed by `memory`/`alu`).
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  high only in IDLE
- `instr`  in  8  [7:4] opcode, [3:0] memory address
- `imm`  in  8  immediate operand, sampled with `instr`
- `mem_enable`  out  1  memory access strobe
- `read_write`  out  1  1 = read, 0 = write
- `address_bus`  out  4  memory address
- `data_bus_in`  out  8  memory write data
- `data_bus_out`  in  8  memory read data, valid the cycle after a read strobe
- `alu_enable`  out  1  ALU compute strobe
- `mode`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 compare
- `alu_a`  out  8  ALU operand A (always `acc`)
- `alu_b`  out  8  ALU operand B
- `sum`, `zero_flag`, `carry_flag`  in  8/1/1  ALU result, valid the cycle after `alu_enable`
- `acc`  out  8  accumulator
- `z`, `c`  out  1  architectural zero/carry flags
- `done`  out  1  one-cycle completion pulse

## Operation
- Handshake: instruction accepted on the edge where `instr_valid && instr_ready`; `instr`/`imm` latched into `ir`/`imr`. `instr_valid` outside IDLE is ignored.
- Moore FSM states: IDLE, RD, RDW, EX, EXW, WR. All memory/ALU control outputs are decoded from state plus latched registers only.
- RD: `mem_enable`=1, `read_write`=1, `address_bus`=ir[3:0]. RDW: `data_bus_out` latched into `opb`.
- EX: `alu_enable`=1, `mode` from opcode, `alu_a`=acc, `alu_b`=opb (register form) or imr (immediate form). EXW: `acc`<=`sum` (except compare), `z`/`c`<=ALU flags.
- WR: `mem_enable`=1, `read_write`=0, `address_bus` and `data_bus_in` per opcode.
- Opcode paths:
  - LD 0000: RD, RDW (acc<=mem[a]).
  - ST 0001: WR (mem[a]<=acc).
  - MI 0010: WR (mem[a]<=imm).
  - MR 0011: RD, RDW, WR (mem[acc[3:0]]<=mem[a]).
  - SUM 0100/SB 0101/ANR 0110/CM 0111/ORR 1000/XRR 1010: RD, RDW, EX, EXW.
  - SMI 1100/SBI 1101/ANI 1110/CMI 1111/ORI 1001/XRI 1011: EX, EXW.
- After the last state, return to IDLE with `done`=1 for exactly that IDLE cycle; `acc`/`z`/`c`/memory already reflect the result.
- Flags change only on ALU ops; LD/ST/MI/MR leave `z`,`c` unchanged. CM/CMI update flags only; `acc` is unchanged.
- Idle outputs: `mem_enable`=0, `alu_enable`=0, `read_write`=1, `address_bus`/`data_bus_in`/`mode`=0.

## Timing
- Latency, accept edge to `done` cycle: ST/MI 2, LD 3, immediate ALU 3, MR 4, register ALU 5 cycles.
- Back-to-back: a new instruction may be accepted in the `done` cycle, giving zero bubble cycles.
- Reset: state IDLE, `acc`=0, `z`=`c`=0, `done`=0, `instr_ready`=1 in the next cycle, control outputs at idle values.
- Reset mid-operation aborts without updating `acc` or flags. A write strobe present at the reset edge may still commit in `memory`, which is not reset.
- 8-bit arithmetic wraps, with carry/borrow taken from the ALU. Sequencer adds no width extension.
- MR with acc[3:0]==a: the write still occurs with the same value.

## Test plan
- Reset, then MI a=5 imm=9 -> `done` 2 cycles after accept; LD a=5 -> `acc`=9, `z`,`c` unchanged (0).
- Starting from acc=9: SMI imm=5 -> `acc`=14, `z`=0, `c`=0, `done` at cycle 3; ST a=1, then LD a=1 -> `acc`=14.
- acc=0xF0, mem[2]=0x20, SUM a=2 -> `acc`=0x10, `c`=1, latency 5; CMI imm=0x10 -> `z`=1, `acc` stays 0x10.
- MR: acc=3, mem[7]=0xAA, MR a=7 -> mem[3]=0xAA, observed as a WR cycle with `address_bus`=3, `data_bus_in`=0xAA.
- Hold `instr_valid` high continuously with 4 queued instructions -> each accepted in its predecessor's `done` cycle; `instr_valid` during busy states is never accepted.
- Assert `reset` during EX of SUM -> `acc`=0, `z`=`c`=0, IDLE next cycle, no `done` pulse.
